// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
//   Drives an 8:1 bit selector so that its output becomes a framed serial
//   bit stream. A word is captured on an accepted start, the select lines
//   step through all eight channels (each held i_div+1 clocks), and the
//   selector is held disabled whenever no transfer is running.
//
// Ports
//   i_clk    : clock, all logic on rising edge
//   i_rst    : synchronous reset, active-high
//   i_start  : transfer request, accepted only in IDLE
//   i_data   : word to serialise, sampled on the accepted start
//   i_div    : bit period minus one, sampled on the accepted start
//   i_abort  : abort of a running transfer
//   o_i      : captured word, drives selector data inputs
//   o_s      : channel select, drives selector select inputs
//   o_en     : selector disable (1 forces selector output to 0)
//   o_busy   : high while running
//   o_last   : high while the 8th bit is presented
//   o_done   : one-cycle pulse on normal completion
module mux_sel_sequencer #(
  parameter int unsigned CNT_W     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [7:0]       i_data,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_abort,
  output logic [7:0]       o_i,
  output logic [2:0]       o_s,
  output logic             o_en,
  output logic             o_busy,
  output logic             o_last,
  output logic             o_done
);

  localparam logic [2:0] S_FIRST = MSB_FIRST ? 3'd7 : 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [7:0]       r_i,       w_i_nxt;
  logic [2:0]       r_s,       w_s_nxt;
  logic             r_en,      w_en_nxt;
  logic             r_busy,    w_busy_nxt;
  logic             r_last,    w_last_nxt;
  logic             r_done,    w_done_nxt;
  logic [CNT_W-1:0] r_div_lat, w_div_lat_nxt;
  logic [CNT_W-1:0] r_div_cnt, w_div_cnt_nxt;
  logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;

  logic             w_bit_end;
  logic             w_last_bit;
  logic [2:0]       w_s_step;

  // Bit period ends when the divider has counted up to the latched value.
  assign w_bit_end  = (r_div_cnt == r_div_lat);
  assign w_last_bit = (r_bit_cnt == 3'd7);
  assign w_s_step   = MSB_FIRST ? (r_s - 3'd1) : (r_s + 3'd1);

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_i       <= 8'd0;
      r_s       <= 3'd0;
      r_en      <= 1'b1;
      r_busy    <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_div_lat <= '0;
      r_div_cnt <= '0;
      r_bit_cnt <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_i       <= w_i_nxt;
      r_s       <= w_s_nxt;
      r_en      <= w_en_nxt;
      r_busy    <= w_busy_nxt;
      r_last    <= w_last_nxt;
      r_done    <= w_done_nxt;
      r_div_lat <= w_div_lat_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_abort)                      w_state_nxt = ST_IDLE;
        else if (w_bit_end && w_last_bit) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    w_i_nxt       = r_i;
    w_s_nxt       = r_s;
    w_en_nxt      = r_en;
    w_busy_nxt    = r_busy;
    w_last_nxt    = r_last;
    w_done_nxt    = 1'b0;
    w_div_lat_nxt = r_div_lat;
    w_div_cnt_nxt = r_div_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_i_nxt       = i_data;
          w_div_lat_nxt = i_div;
          w_s_nxt       = S_FIRST;
          w_en_nxt      = 1'b0;
          w_busy_nxt    = 1'b1;
          w_last_nxt    = 1'b0;
          w_div_cnt_nxt = '0;
          w_bit_cnt_nxt = 3'd0;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          w_s_nxt       = 3'd0;
          w_en_nxt      = 1'b1;
          w_busy_nxt    = 1'b0;
          w_last_nxt    = 1'b0;
          w_div_cnt_nxt = '0;
          w_bit_cnt_nxt = 3'd0;
        end else if (w_bit_end) begin
          w_div_cnt_nxt = '0;
          if (w_last_bit) begin
            // s keeps its final value through DONE and IDLE
            w_en_nxt   = 1'b1;
            w_busy_nxt = 1'b0;
            w_last_nxt = 1'b0;
            w_done_nxt = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_s_nxt       = w_s_step;
            w_last_nxt    = (r_bit_cnt == 3'd6);
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign o_i    = r_i;
  assign o_s    = r_s;
  assign o_en   = r_en;
  assign o_busy = r_busy;
  assign o_last = r_last;
  assign o_done = r_done;

endmodule
